// File: rtl/cva6_fifo_stream_out_if.sv
// Stream-out bundle: FIFO read port on one side, valid/ready stream plus status on the other.
interface cva6_fifo_stream_out_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_pop_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [1:0]            occupancy_o;
  logic [CNT_WIDTH-1:0]  beat_cnt_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  // Output-stage side: consumes the FIFO read port, produces the stream.
  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, occupancy_o, beat_cnt_o, stall_cnt_o
  );

  // Environment side: upstream FIFO and downstream consumer.
  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, occupancy_o, beat_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/cva6_fifo_stream_out.sv
// Two-entry skid-buffered output stage for a non-fall-through FIFO.
// fifo_pop_o depends only on the buffer count, never on ready_i.
// Optional performance counters: define CVA6_STREAM_OUT_PERF_EN.
module cva6_fifo_stream_out #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  cva6_fifo_stream_out_if.master        bus
);
  localparam int unsigned OCC_W = 2;

  logic [OCC_W-1:0]      cnt_q, cnt_n, wr_idx;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_n, slot1_q, slot1_n;
  logic                  valid, fill, drain;

  assign valid           = (cnt_q != '0);
  assign fill            = ~bus.fifo_empty_i & (cnt_q < OCC_W'(2)) & ~flush_i & ~rst_i;
  assign drain           = valid & bus.ready_i;
  assign wr_idx          = cnt_q - OCC_W'(drain);

  assign bus.fifo_pop_o  = fill;
  assign bus.valid_o     = valid;
  assign bus.data_o      = slot0_q;
  assign bus.occupancy_o = cnt_q;

  // Next occupancy: flush empties the buffer, otherwise fill/drain net out.
  always_comb begin
    cnt_n = cnt_q;
    if (flush_i) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt_q + OCC_W'(fill) - OCC_W'(drain);
    end
  end

  // Slot update: skid shifts forward on drain, new entry lands behind the survivors.
  always_comb begin
    slot0_n = slot0_q;
    slot1_n = slot1_q;
    if (drain && (cnt_q == OCC_W'(2))) begin
      slot0_n = slot1_q;
    end
    if (fill) begin
      if (wr_idx == '0) begin
        slot0_n = bus.fifo_data_i;
      end else begin
        slot1_n = bus.fifo_data_i;
      end
    end
  end

  // Occupancy register; count of 3 can never be reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_n;
      assert (cnt_q != OCC_W'(3));
    end
  end

  // Payload slots carry no reset; contents are ignored while the count is zero.
  always_ff @(posedge clk_i) begin
    slot0_q <= slot0_n;
    slot1_q <= slot1_n;
  end

`ifdef CVA6_STREAM_OUT_PERF_EN
  logic [CNT_WIDTH-1:0] beat_q, stall_q;

  // Saturating beat and stall counters, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (drain && (beat_q != '1)) begin
        beat_q <= beat_q + CNT_WIDTH'(1);
      end
      if (valid && !bus.ready_i && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.beat_cnt_o  = beat_q;
  assign bus.stall_cnt_o = stall_q;
`else
  assign bus.beat_cnt_o  = CNT_WIDTH'(0);
  assign bus.stall_cnt_o = CNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_cva6_fifo_stream_out.sv
// Bench for cva6_fifo_stream_out: directed vector table, hand sequences, random stream.
module tb_cva6_fifo_stream_out;
  localparam int unsigned DW      = 32;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef CVA6_STREAM_OUT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, rst, flush;

  cva6_fifo_stream_out_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  cva6_fifo_stream_out #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  logic          s_pop, s_valid, s_empty;
  logic [1:0]    s_occ;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_beat, s_stall;

  int            beat_m  = 0;
  int            stall_m = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  typedef struct {
    int unsigned   preload;
    logic [DW-1:0] base;
    logic [DW-1:0] stride;
    logic          rst;
    logic          flush;
    logic          ready;
    logic          e_pop;
    logic          e_valid;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input int unsigned pl, input logic [DW-1:0] base, input logic [DW-1:0] stride,
                     input logic r, input logic f, input logic rdy,
                     input logic ep, input logic ev, input logic [1:0] eo, input logic [DW-1:0] ed);
    vec_t v;
    v.preload = pl; v.base = base; v.stride = stride;
    v.rst = r; v.flush = f; v.ready = rdy;
    v.e_pop = ep; v.e_valid = ev; v.e_occ = eo; v.e_data = ed;
    tbl.push_back(v);
  endtask

  task automatic preload(input int unsigned n, input logic [DW-1:0] base, input logic [DW-1:0] stride);
    for (int i = 0; i < int'(n); i++) fifo_q.push_back(base + DW'(i) * stride);
  endtask

  // One clock cycle: drive, sample at negedge, check invariants and scoreboard, advance.
  task automatic step(input logic r, input logic f, input logic rdy);
    logic alt_pop;
    rst = r;
    flush = f;
    bus.ready_i = rdy;
    bus.fifo_empty_i = (fifo_q.size() == 0);
    bus.fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    @(negedge clk);
    s_pop = bus.fifo_pop_o; s_valid = bus.valid_o; s_occ = bus.occupancy_o;
    s_data = bus.data_o; s_beat = bus.beat_cnt_o; s_stall = bus.stall_cnt_o;
    s_empty = bus.fifo_empty_i;

    bus.ready_i = ~rdy;
    #1 alt_pop = bus.fifo_pop_o;
    bus.ready_i = rdy;
    #1;
    chk("pop_vs_ready", 32'(alt_pop), 32'(s_pop));
    chk("pop_rule", 32'(s_pop), 32'(~s_empty & (s_occ < 2'd2) & ~f & ~r));
    chk("pop_empty", 32'(s_pop & s_empty), 32'd0);
    chk("occ_range", 32'(s_occ == 2'd3), 32'd0);
    chk("valid_occ", 32'(s_valid), 32'(s_occ != 2'd0));
    chk("beat_cnt", 32'(s_beat), PERF ? 32'(beat_m) : 32'd0);
    chk("stall_cnt", 32'(s_stall), PERF ? 32'(stall_m) : 32'd0);
    if (prev_stall) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data", s_data, prev_data);
    end

    if (s_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%h required=none", s_data);
      end else begin
        chk("sb_data", s_data, exp_q.pop_front());
      end
    end
    if (r || f) exp_q.delete();
    if (s_pop) exp_q.push_back(fifo_q[0]);

    if (r) begin
      beat_m = 0;
      stall_m = 0;
    end else begin
      if (s_valid && rdy && beat_m < CNT_MAX) beat_m++;
      if (s_valid && !rdy && stall_m < CNT_MAX) stall_m++;
    end
    prev_stall = s_valid & ~rdy & ~r & ~f;
    prev_data  = s_data;

    @(posedge clk);
    #1;
    if (s_pop) void'(fifo_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b0;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i = '0;
    @(posedge clk);
    #1;

    // reset with a loaded FIFO, then stream 0x11,0x22,0x33 with ready high
    add(3, 'h11, 'h11, 1, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0,       0, 0, 1,  1, 0, 0, 0);
    add(0, 0, 0,       0, 0, 1,  1, 1, 1, 'h11);
    add(0, 0, 0,       0, 0, 1,  1, 1, 1, 'h22);
    add(0, 0, 0,       0, 0, 1,  0, 1, 1, 'h33);
    add(0, 0, 0,       0, 0, 1,  0, 0, 0, 0);
    // backpressure with four entries, then release
    add(4, 'hA0, 1,    0, 0, 0,  1, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0,  1, 1, 1, 'hA0);
    add(0, 0, 0,       0, 0, 0,  0, 1, 2, 'hA0);
    add(0, 0, 0,       0, 0, 0,  0, 1, 2, 'hA0);
    add(0, 0, 0,       0, 0, 1,  0, 1, 2, 'hA0);
    add(0, 0, 0,       0, 0, 1,  1, 1, 1, 'hA1);
    add(0, 0, 0,       0, 0, 1,  1, 1, 1, 'hA2);
    add(0, 0, 0,       0, 0, 1,  0, 1, 1, 'hA3);
    add(0, 0, 0,       0, 0, 1,  0, 0, 0, 0);
    // flush while full
    add(4, 'hB0, 1,    0, 0, 0,  1, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0,  1, 1, 1, 'hB0);
    add(0, 0, 0,       0, 1, 0,  0, 1, 2, 'hB0);
    add(0, 0, 0,       0, 0, 0,  1, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0,  1, 1, 1, 'hB2);
    add(0, 0, 0,       0, 0, 1,  0, 1, 2, 'hB2);
    add(0, 0, 0,       0, 0, 1,  0, 1, 1, 'hB3);
    add(0, 0, 0,       0, 0, 1,  0, 0, 0, 0);
    // flush with one entry and a non-empty FIFO suppresses the pop
    add(2, 'hC0, 1,    0, 0, 0,  1, 0, 0, 0);
    add(0, 0, 0,       0, 1, 0,  0, 1, 1, 'hC0);
    add(0, 0, 0,       0, 0, 1,  1, 0, 0, 0);
    add(0, 0, 0,       0, 0, 1,  0, 1, 1, 'hC1);
    add(0, 0, 0,       0, 0, 1,  0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      preload(tbl[i].preload, tbl[i].base, tbl[i].stride);
      step(tbl[i].rst, tbl[i].flush, tbl[i].ready);
      chk($sformatf("row%0d_pop", i), 32'(s_pop), 32'(tbl[i].e_pop));
      chk($sformatf("row%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d_occ", i), 32'(s_occ), 32'(tbl[i].e_occ));
      if (tbl[i].e_valid) chk($sformatf("row%0d_data", i), s_data, tbl[i].e_data);
    end

    // reset while full and ready high
    preload(4, 'hD0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 1);
    chk("rstmid_pop", 32'(s_pop), 32'd0);
    chk("rstmid_occ_before", 32'(s_occ), 32'd2);
    step(1, 0, 1);
    chk("rstmid_valid", 32'(s_valid), 32'd0);
    chk("rstmid_occ", 32'(s_occ), 32'd0);
    chk("rstmid_pop_hold", 32'(s_pop), 32'd0);
    chk("rstmid_beat", 32'(s_beat), 32'd0);
    chk("rstmid_stall", 32'(s_stall), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);

    // ten cycles: four accepted beats and three stalls
    step(1, 0, 0);
    preload(4, 'hE0, 1);
    begin
      logic [9:0] rdy_pat;
      rdy_pat = 10'b11_1111_0001;
      for (int i = 0; i < 10; i++) step(0, 0, rdy_pat[i]);
    end
    step(0, 0, 0);
    chk("perf_beats", 32'(s_beat), PERF ? 32'd4 : 32'd0);
    chk("perf_stalls", 32'(s_stall), PERF ? 32'd3 : 32'd0);

    // drive both counters into saturation
    preload(1, 'hF0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    preload(20, 'h100, 1);
    for (int i = 0; i < 25; i++) step(0, 0, 1);
    chk("sat_beats", 32'(s_beat), PERF ? 32'd15 : 32'd0);
    chk("sat_stalls", 32'(s_stall), PERF ? 32'd15 : 32'd0);
    step(0, 0, 1);
    chk("sat_beats_hold", 32'(s_beat), PERF ? 32'd15 : 32'd0);

    // random ready, FIFO fill, rare flush and reset
    for (int i = 0; i < 10000; i++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) fifo_q.push_back($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    chk("final_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(s_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
